cmp_stim_driver: RTL

CMP_STIM_DRIVER -- requirements
Module: cmp_stim_driver

---
 rtl/cmp_stim_driver_if.sv | 40 ++++
 rtl/cmp_stim_driver.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/cmp_stim_driver_if.sv
// cmp_stim_driver_if
// Bundles the run-control, operand and response signals of cmp_stim_driver.
//   master modport : seen by the driver (drives operands, status and counters)
//   slave modport  : seen by the environment (drives run control and the
//                    comparator response flags)
// Signals:
//   i_start     run request
//   iv_count    number of vectors per run
//   ov_x, ov_y  operands presented to the comparator under test
//   i_equal, i_greater, i_less  comparator response flags
//   o_busy      run in progress
//   o_done      one-cycle end-of-run pulse
//   ov_pass_cnt, ov_fail_cnt    per-run result counters
//   o_error     sticky failure flag for the current run
interface cmp_stim_driver_if #(
    parameter int unsigned p_WIDTH = 32
);
    logic               i_start;
    logic [15:0]        iv_count;
    logic [p_WIDTH-1:0] ov_x;
    logic [p_WIDTH-1:0] ov_y;
    logic               i_equal;
    logic               i_greater;
    logic               i_less;
    logic               o_busy;
    logic               o_done;
    logic [15:0]        ov_pass_cnt;
    logic [15:0]        ov_fail_cnt;
    logic               o_error;

    modport master (
        input  i_start, iv_count, i_equal, i_greater, i_less,
        output ov_x, ov_y, o_busy, o_done, ov_pass_cnt, ov_fail_cnt, o_error
    );

    modport slave (
        output i_start, iv_count, i_equal, i_greater, i_less,
        input  ov_x, ov_y, o_busy, o_done, ov_pass_cnt, ov_fail_cnt, o_error
    );
endinterface

// File: rtl/cmp_stim_driver.sv
// cmp_stim_driver
// Self-running stimulus generator and checker for a magnitude comparator.
// Each vector takes X from a Galois LFSR and derives Y so that the three
// relations (equal, X greater, X less) rotate, holds the operands for
// p_SETTLE cycles, then checks the comparator's response flags.
//
// Ports:
//   i_clk    sole clock
//   i_reset  synchronous, active-high reset
//   bus      cmp_stim_driver_if.master (run control, operands, response
//            flags, busy/done status, pass/fail counters, sticky error)
//
// Parameters:
//   p_WIDTH  operand width
//   p_SETTLE operand settle cycles before the response is sampled (1..255)
//   p_SEED   nonzero LFSR seed, low p_WIDTH bits used
//
// Build option:
//   CMP_STIM_ONEHOT_CHK_EN  when defined, a vector passes only if exactly one
//                           response flag is set and it is the expected one;
//                           otherwise only the expected flag is examined.
module cmp_stim_driver #(
    parameter int unsigned p_WIDTH  = 32,
    parameter int unsigned p_SETTLE = 4,
    parameter logic [31:0] p_SEED   = 32'hACE10001
) (
    input  logic               i_clk,
    input  logic               i_reset,
    cmp_stim_driver_if.master  bus
);

    // x^32 + x^22 + x^2 + x + 1 in right-shifting Galois form, cut to width
    localparam logic [p_WIDTH-1:0] TAPS_W      = p_WIDTH'(32'h80200003);
    localparam logic [p_WIDTH-1:0] SEED_W      = p_WIDTH'(p_SEED);
    localparam logic [p_WIDTH-1:0] ONE_W       = p_WIDTH'(1);
    localparam logic [7:0]         SETTLE_LAST = 8'(p_SETTLE - 1);

    typedef enum logic [2:0] {
        IDLE,
        DRIVE,
        SETTLE,
        CHECK,
        DONE
    } driverState_t;

    driverState_t       state_q;
    logic [p_WIDTH-1:0] lfsr_q;
    logic [p_WIDTH-1:0] x_q;
    logic [p_WIDTH-1:0] y_q;
    logic [15:0]        count_q;
    logic [15:0]        vecIndex_q;
    logic [1:0]         vecClass_q;
    logic [7:0]         settle_q;
    logic [15:0]        passCnt_q;
    logic [15:0]        failCnt_q;
    logic               error_q;
    logic               busy_q;
    logic               done_q;

    logic [p_WIDTH-1:0] lfsr_d;
    logic [p_WIDTH-1:0] y_d;
    logic [15:0]        vecIndex_d;
    logic [1:0]         vecClass_d;
    logic               expEqual;
    logic               expGreater;
    logic               expLess;
    logic               vecPass;

    // Next LFSR value, the Y operand for the current class, and the verdict
    // for the operands currently held on ov_x/ov_y. Y is allowed to wrap, and
    // the expected relation is judged on the wrapped values as plain unsigned
    // numbers, so X=0 in class 1 expects "less" and X=all-ones in class 2
    // expects "greater".
    always_comb begin
        lfsr_d     = (lfsr_q >> 1) ^ (lfsr_q[0] ? TAPS_W : '0);
        vecIndex_d = vecIndex_q + 16'd1;
        vecClass_d = (vecClass_q == 2'd2) ? 2'd0 : vecClass_q + 2'd1;

        unique case (vecClass_q)
            2'd1:    y_d = lfsr_q - ONE_W;
            2'd2:    y_d = lfsr_q + ONE_W;
            default: y_d = lfsr_q;
        endcase

        expEqual   = (x_q == y_q);
        expGreater = (x_q >  y_q);
        expLess    = (x_q <  y_q);

`ifdef CMP_STIM_ONEHOT_CHK_EN
        vecPass = ({bus.i_equal, bus.i_greater, bus.i_less} ==
                   {expEqual, expGreater, expLess});
`else
        vecPass = (expEqual   & bus.i_equal)   |
                  (expGreater & bus.i_greater) |
                  (expLess    & bus.i_less);
`endif
    end

    // Run sequencer. o_busy is registered alongside the state so it is high
    // exactly in DRIVE/SETTLE/CHECK; o_done is registered on the way out of
    // DONE, so it appears in the cycle after DONE and a reset that lands
    // before then never lets it through.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q    <= IDLE;
            lfsr_q     <= SEED_W;
            x_q        <= '0;
            y_q        <= '0;
            count_q    <= '0;
            vecIndex_q <= '0;
            vecClass_q <= '0;
            settle_q   <= '0;
            passCnt_q  <= '0;
            failCnt_q  <= '0;
            error_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (bus.i_start) begin
                        count_q    <= bus.iv_count;
                        passCnt_q  <= '0;
                        failCnt_q  <= '0;
                        error_q    <= 1'b0;
                        vecIndex_q <= '0;
                        vecClass_q <= '0;
                        if (bus.iv_count == 16'd0) begin
                            state_q <= DONE;
                        end else begin
                            state_q <= DRIVE;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                DRIVE: begin
                    x_q      <= lfsr_q;
                    y_q      <= y_d;
                    settle_q <= SETTLE_LAST;
                    state_q  <= SETTLE;
                end
                SETTLE: begin
                    if (settle_q == 8'd0) begin
                        state_q <= CHECK;
                    end else begin
                        settle_q <= settle_q - 8'd1;
                    end
                end
                CHECK: begin
                    if (vecPass) begin
                        passCnt_q <= passCnt_q + 16'd1;
                    end else begin
                        failCnt_q <= failCnt_q + 16'd1;
                        error_q   <= 1'b1;
                    end
                    lfsr_q     <= lfsr_d;
                    vecIndex_q <= vecIndex_d;
                    vecClass_q <= vecClass_d;
                    if (vecIndex_d == count_q) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                    end else begin
                        state_q <= DRIVE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ov_x        = x_q;
    assign bus.ov_y        = y_q;
    assign bus.o_busy      = busy_q;
    assign bus.o_done      = done_q;
    assign bus.ov_pass_cnt = passCnt_q;
    assign bus.ov_fail_cnt = failCnt_q;
    assign bus.o_error     = error_q;

endmodule
